// File: rtl/booth_ctrl_if.sv
// Handshake/command bundle between the Booth sequencing controller and the A/B/C datapath.
interface booth_ctrl_if;
   logic       Start;
   logic [1:0] Q_pair;
   logic       Load;
   logic       Add;
   logic       Addc;
   logic       Shift;
   logic       Busy;
   logic       Done;

   modport master (output Start, Q_pair, input Load, Add, Addc, Shift, Busy, Done);
   modport slave  (input Start, Q_pair, output Load, Add, Addc, Shift, Busy, Done);
endinterface

// File: rtl/booth_ctrl.sv
// Radix-2 Booth multiplier sequencer: issues Load/Add/Addc/Shift with settle spacing.
// Optional macro BOOTH_SKIP_EN: NOP iterations (Q_pair 00/11) bypass OP and WAIT_O.
module booth_ctrl #(
   parameter int n      = 8,
   parameter int SETTLE = 2
) (
   input  logic        Clock,
   input  logic        Reset,
   booth_ctrl_if.slave bus
);
   localparam int             CW        = $clog2(n + 1);
   localparam logic [CW-1:0]  N_ITER    = CW'(n);
   localparam logic [2:0]     SETTLE_M1 = 3'(SETTLE - 1);

   typedef enum logic [3:0] {
      IDLE, LOAD, WAIT_L, EVAL, OP, WAIT_O, SHIFT, WAIT_S, DONE
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   iter_q, iter_d;
   logic [2:0]      settle_q, settle_d;
   logic [1:0]      op_sel_q, op_sel_d;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q  <= IDLE;
         iter_q   <= '0;
         settle_q <= '0;
         op_sel_q <= '0;
      end else begin
         state_q  <= state_d;
         iter_q   <= iter_d;
         settle_q <= settle_d;
         op_sel_q <= op_sel_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      iter_d   = iter_q;
      settle_d = settle_q;
      op_sel_d = op_sel_q;
      case (state_q)
         IDLE:   if (bus.Start) state_d = LOAD;
         LOAD: begin
            iter_d   = N_ITER;
            settle_d = SETTLE_M1;
            state_d  = WAIT_L;
         end
         WAIT_L: begin
            if (settle_q == 3'd0) state_d = EVAL;
            else                  settle_d = settle_q - 3'd1;
         end
         EVAL: begin
            op_sel_d = bus.Q_pair;
`ifdef BOOTH_SKIP_EN
            state_d  = (bus.Q_pair[1] == bus.Q_pair[0]) ? SHIFT : OP;
`else
            state_d  = OP;
`endif
         end
         OP: begin
            // NOP iterations still settle so latency stays data-independent
            settle_d = SETTLE_M1;
            state_d  = WAIT_O;
         end
         WAIT_O: begin
            if (settle_q == 3'd0) state_d = SHIFT;
            else                  settle_d = settle_q - 3'd1;
         end
         SHIFT: begin
            settle_d = SETTLE_M1;
            state_d  = WAIT_S;
         end
         WAIT_S: begin
            if (settle_q == 3'd0) begin
               if (iter_q != '0) iter_d = iter_q - CW'(1);
               state_d = (iter_q <= CW'(1)) ? DONE : EVAL;
            end else begin
               settle_d = settle_q - 3'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.Load  = 1'b0;
      bus.Add   = 1'b0;
      bus.Addc  = 1'b0;
      bus.Shift = 1'b0;
      bus.Done  = 1'b0;
      bus.Busy  = 1'b0;
      case (state_q)
         LOAD:  bus.Load  = 1'b1;
         OP: begin
            bus.Add  = (op_sel_q == 2'b01);
            bus.Addc = (op_sel_q == 2'b10);
         end
         SHIFT: bus.Shift = 1'b1;
         DONE:  bus.Done  = 1'b1;
         default: ;
      endcase
      bus.Busy = (state_q != IDLE) && (state_q != DONE);
   end
endmodule

// File: tb/tb_booth_ctrl.sv
// Bench for booth_ctrl: two instances (SETTLE=2 and SETTLE=1) each driving a behavioural
// A/B/C datapath; command traces are compared against a cycle timeline built from Booth rules.
module tb_booth_ctrl;
`ifdef BOOTH_SKIP_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   logic Clock = 1'b0;
   logic Reset;
   always #5 Clock = ~Clock;

   logic [1:0]       start_v;
   logic [7:0]       mpl_v [2];
   logic [7:0]       mcd_v [2];
   logic [1:0]       load_v, add_v, addc_v, shift_v, busy_v, done_v;
   logic [1:0][15:0] prod_v;

   for (genvar g = 0; g < 2; g++) begin : u
      booth_ctrl_if bus ();
      logic [8:0] a_q = '0;
      logic [8:0] b_q = '0;
      logic [7:0] c_q = '0;

      booth_ctrl #(.n(8), .SETTLE(g == 0 ? 2 : 1)) dut (
         .Clock (Clock),
         .Reset (Reset),
         .bus   (bus)
      );

      assign bus.Start  = start_v[g];
      assign bus.Q_pair = b_q[1:0];
      assign load_v[g]  = bus.Load;
      assign add_v[g]   = bus.Add;
      assign addc_v[g]  = bus.Addc;
      assign shift_v[g] = bus.Shift;
      assign busy_v[g]  = bus.Busy;
      assign done_v[g]  = bus.Done;
      assign prod_v[g]  = {a_q[7:0], b_q[8:1]};

      always @(posedge Clock) begin
         if (bus.Load) begin
            a_q <= '0;
            b_q <= {mpl_v[g], 1'b0};
            c_q <= mcd_v[g];
         end else if (bus.Add)   a_q <= a_q + {c_q[7], c_q};
         else if (bus.Addc)      a_q <= a_q + ~{c_q[7], c_q} + 9'd1;
         else if (bus.Shift)     {a_q, b_q} <= {a_q[8], a_q, b_q[8:1]};
      end
   end

   int nchk = 0;
   int nerr = 0;
   int exp_tr [0:255];

   task automatic chk(input string name, input int act, input int exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // 0 none, 1 Load, 2 Add, 3 Addc, 4 Shift, 5 Done, 7 more than one command
   function automatic int obs(input int s);
      int k, code;
      k = 0; code = 0;
      if (load_v[s])  begin k++; code = 1; end
      if (add_v[s])   begin k++; code = 2; end
      if (addc_v[s])  begin k++; code = 3; end
      if (shift_v[s]) begin k++; code = 4; end
      if (done_v[s])  begin k++; code = 5; end
      return (k > 1) ? 7 : code;
   endfunction

   task automatic build_exp(input logic [7:0] m, input int st, output int done_c);
      int t;
      logic prev;
      logic [1:0] pr;
      for (int i = 0; i < 256; i++) exp_tr[i] = 0;
      exp_tr[1] = 1;
      t = 2 + st;
      prev = 1'b0;
      for (int i = 0; i < 8; i++) begin
         pr = {m[i], prev};
         prev = m[i];
         if (SKIP && (pr[1] == pr[0])) begin
            exp_tr[t+1] = 4;
            t += 2 + st;
         end else begin
            if (pr == 2'b01)      exp_tr[t+1] = 2;
            else if (pr == 2'b10) exp_tr[t+1] = 3;
            exp_tr[t+2+st] = 4;
            t += 3 + 2*st;
         end
      end
      exp_tr[t] = 5;
      done_c = t;
   endtask

   task automatic run_mult(input int s, input logic [7:0] m, input logic [7:0] c, input bit hold,
                           output int done_c, output int nadd, output int naddc,
                           output int nshift, output int nload);
      int exp_done, bad_tr, bad_busy, ob, last, first_bad, ep;
      logic [15:0] prod_seen;
      bit exp_busy;
      build_exp(m, (s == 0) ? 2 : 1, exp_done);
      if (hold) exp_tr[exp_done+2] = 1;
      last = exp_done + (hold ? 2 : 1);
      done_c = -1; nadd = 0; naddc = 0; nshift = 0; nload = 0;
      bad_tr = 0; bad_busy = 0; first_bad = -1; prod_seen = '0;
      mpl_v[s] = m; mcd_v[s] = c; start_v[s] = 1'b1;
      @(posedge Clock); #1;
      if (!hold) start_v[s] = 1'b0;
      for (int cyc = 1; cyc <= last; cyc++) begin
         ob = obs(s);
         case (ob)
            1: nload++;
            2: nadd++;
            3: naddc++;
            4: nshift++;
            5: if (done_c < 0) begin done_c = cyc; prod_seen = prod_v[s]; end
            default: ;
         endcase
         if (ob != exp_tr[cyc]) begin
            bad_tr++;
            if (first_bad < 0) first_bad = cyc;
         end
         exp_busy = (cyc < exp_done) || (hold && cyc == exp_done + 2);
         if (busy_v[s] !== exp_busy) bad_busy++;
         @(posedge Clock); #1;
      end
      start_v[s] = 1'b0;
      chk($sformatf("trace_mismatch_cycles s%0d m%02h first@%0d", s, m, first_bad), bad_tr, 0);
      chk($sformatf("busy_mismatch_cycles s%0d m%02h", s, m), bad_busy, 0);
      chk($sformatf("done_cycle s%0d m%02h", s, m), done_c, exp_done);
      ep = $signed(m) * $signed(c);
      chk($sformatf("product s%0d %02h*%02h", s, m, c), int'($signed(prod_seen)), ep);
   endtask

   typedef struct {
      logic [7:0] m;
      logic [7:0] c;
      int         s;
      int         done_ns;
      int         done_sk;
      int         nadd;
      int         naddc;
   } vec_t;

   vec_t tbl [4];

   initial begin
      int dc, na, nac, ns, nl, dcount;
      tbl[0] = '{8'h01, 8'h05, 0, 60, 42, 1, 1};
      tbl[1] = '{8'hFF, 8'h03, 0, 60, 39, 0, 1};
      tbl[2] = '{8'h5A, 8'h85, 1, 43, 39, 3, 3};
      tbl[3] = '{8'h00, 8'h7F, 0, 60, 36, 0, 0};

      Reset = 1'b1;
      start_v = '0;
      mpl_v[0] = '0; mpl_v[1] = '0; mcd_v[0] = '0; mcd_v[1] = '0;
      repeat (2) @(posedge Clock);
      #1;
      chk("reset_outputs", int'({load_v, add_v, addc_v, shift_v, busy_v, done_v}), 0);
      Reset = 1'b0;
      @(posedge Clock); #1;

      foreach (tbl[i]) begin
         run_mult(tbl[i].s, tbl[i].m, tbl[i].c, 1'b0, dc, na, nac, ns, nl);
         chk($sformatf("tbl%0d done", i), dc, SKIP ? tbl[i].done_sk : tbl[i].done_ns);
         chk($sformatf("tbl%0d add_count", i), na, tbl[i].nadd);
         chk($sformatf("tbl%0d addc_count", i), nac, tbl[i].naddc);
         chk($sformatf("tbl%0d shift_count", i), ns, 8);
         chk($sformatf("tbl%0d load_count", i), nl, 1);
      end

      // Start held high: one multiply, next Load two cycles after Done
      run_mult(0, 8'h33, 8'h11, 1'b1, dc, na, nac, ns, nl);
      chk("hold_load_count", nl, 2);
      Reset = 1'b1;
      @(posedge Clock); #1;
      Reset = 1'b0;
      @(posedge Clock); #1;

      // Reset in cycle 20 of a multiply
      mpl_v[0] = 8'hA7; mcd_v[0] = 8'h19; start_v[0] = 1'b1;
      @(posedge Clock); #1;
      start_v[0] = 1'b0;
      repeat (19) begin @(posedge Clock); #1; end
      Reset = 1'b1;
      @(posedge Clock); #1;
      chk("midop_reset_outputs", int'({load_v, add_v, addc_v, shift_v, busy_v, done_v}), 0);
      Reset = 1'b0;
      dcount = 0;
      repeat (70) begin
         @(posedge Clock); #1;
         if (done_v[0] || busy_v[0]) dcount++;
      end
      chk("no_activity_after_reset", dcount, 0);
      run_mult(0, 8'hA7, 8'h19, 1'b0, dc, na, nac, ns, nl);

      for (int r = 0; r < 8; r++) begin
         run_mult(int'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'b0, dc, na, nac, ns, nl);
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
